// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI converter configuration sequencer.
package spi_cfg_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 16;

    localparam logic TGT_ADC = 1'b0;
    localparam logic TGT_DAC = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STARTUP = 3'd1,
        ISSUE   = 3'd2,
        GAP     = 3'd3,
        DONE    = 3'd4
    } state_t;

    // One table entry: target converter plus register address/data (33 bits)
    typedef struct packed {
        logic              tgt;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_entry_t;

endpackage

// File: rtl/spi_cfg_table.sv
// Command table: DEPTH x 33-bit distributed RAM, synchronous write, asynchronous read.
// Contents are deliberately not reset so a host-loaded table survives a reset.
module spi_cfg_table
    import spi_cfg_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDXW  = 4
)(
    input  logic            clk,
    input  logic            we,
    input  logic [IDXW-1:0] wr_idx,
    input  cmd_entry_t      wr_entry,
    input  logic [IDXW-1:0] rd_idx,
    output cmd_entry_t      rd_entry_c
);

    cmd_entry_t mem [DEPTH];

    // Host write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    // Asynchronous read of the entry about to be issued
    assign rd_entry_c = mem[rd_idx];

endmodule

// File: rtl/spi_cfg_sequencer.sv
// Replays a host-loaded command table into the LTC2195 / AD9783 driver command ports
// with a startup delay and a fixed gap between triggers.
// Optional build macro: CFG_ABORT_EN adds abort_in to cut a running sequence short.
module spi_cfg_sequencer
    import spi_cfg_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned IDXW        = 4,
    parameter int unsigned STARTUP_DLY = 1000,
    parameter int unsigned CMD_GAP     = 4096
)(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [IDXW:0]     n_cmd_in,
    input  logic              tbl_we_in,
    input  logic [IDXW-1:0]   tbl_idx_in,
    input  logic              tbl_tgt_in,
    input  logic [ADDR_W-1:0] tbl_addr_in,
    input  logic [DATA_W-1:0] tbl_data_in,
`ifdef CFG_ABORT_EN
    input  logic              abort_in,
`endif
    output logic              adc_cmd_trig_out,
    output logic              dac_cmd_trig_out,
    output logic [ADDR_W-1:0] cmd_addr_out,
    output logic [DATA_W-1:0] cmd_data_out,
    output logic [IDXW-1:0]   cmd_idx_out,
    output logic              busy_out,
    output logic              done_out
);

    localparam int unsigned NW = IDXW + 1;

    // Counter reload values; the counter runs load..0 so it spends load+1 cycles in a state
    localparam logic [CNT_W-1:0] STARTUP_LOAD =
        (STARTUP_DLY == 32'd0) ? '0 : CNT_W'(STARTUP_DLY - 32'd1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(CMD_GAP - 32'd1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NW-1:0]     idx_q, idx_d;
    logic [NW-1:0]     n_q, n_d;

    logic              abort_c;
    logic              tbl_we_c;
    logic [NW-1:0]     n_sel_c;
    logic [IDXW-1:0]   rd_idx_c;
    cmd_entry_t        wr_entry_c;
    cmd_entry_t        rd_entry_c;
    cmd_entry_t        issue_entry_c;

`ifdef CFG_ABORT_EN
    assign abort_c = abort_in;
`else
    assign abort_c = 1'b0;
`endif

    // Table is frozen while a sequence is in flight
    assign tbl_we_c   = tbl_we_in && ((state_q == IDLE) || (state_q == DONE));
    assign wr_entry_c = '{tgt: tbl_tgt_in, addr: tbl_addr_in, data: tbl_data_in};

    // Clamp the requested command count to the table depth
    assign n_sel_c = (n_cmd_in > NW'(DEPTH)) ? NW'(DEPTH) : n_cmd_in;

    // Index of the next entry to issue; a start from IDLE always begins at entry 0
    assign rd_idx_c = (state_q == IDLE) ? '0 : idx_q[IDXW-1:0];

    spi_cfg_table #(
        .DEPTH (DEPTH),
        .IDXW  (IDXW)
    ) u_table (
        .clk        (clk_in),
        .we         (tbl_we_c),
        .wr_idx     (tbl_idx_in),
        .wr_entry   (wr_entry_c),
        .rd_idx     (rd_idx_c),
        .rd_entry_c (rd_entry_c)
    );

    // Forward a same-cycle write so a zero-delay start sees the freshly written entry
    assign issue_entry_c = (tbl_we_c && (tbl_idx_in == rd_idx_c)) ? wr_entry_c : rd_entry_c;

    // State and counter registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
        end
    end

    // Next-state, shared down-counter and index sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        n_d     = n_q;
        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    n_d   = n_sel_c;
                    idx_d = '0;
                    cnt_d = STARTUP_LOAD;
                    if ((n_sel_c != '0) && (STARTUP_DLY == 32'd0)) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = STARTUP;
                    end
                end
            end
            STARTUP: begin
                if ((n_q == '0) || abort_c) begin
                    state_d = DONE;
                end else if (cnt_q == '0) begin
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ISSUE: begin
                idx_d   = idx_q + NW'(1);
                cnt_d   = GAP_LOAD;
                state_d = abort_c ? DONE : GAP;
            end
            GAP: begin
                if (abort_c) begin
                    state_d = DONE;
                end else if (cnt_q == '0) begin
                    state_d = (idx_q < n_q) ? ISSUE : DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs, aligned with the state they describe
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            adc_cmd_trig_out <= 1'b0;
            dac_cmd_trig_out <= 1'b0;
            cmd_addr_out     <= '0;
            cmd_data_out     <= '0;
            cmd_idx_out      <= '0;
            busy_out         <= 1'b0;
            done_out         <= 1'b0;
        end else begin
            adc_cmd_trig_out <= (state_d == ISSUE) && (issue_entry_c.tgt == TGT_ADC);
            dac_cmd_trig_out <= (state_d == ISSUE) && (issue_entry_c.tgt == TGT_DAC);
            if (state_d == ISSUE) begin
                cmd_addr_out <= issue_entry_c.addr;
                cmd_data_out <= issue_entry_c.data;
                cmd_idx_out  <= rd_idx_c;
            end
            busy_out <= (state_d == STARTUP) || (state_d == ISSUE) || (state_d == GAP);
            if ((state_q == IDLE) && start_in) begin
                done_out <= 1'b0;
            end else if (state_d == DONE) begin
                done_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Testbench for spi_cfg_sequencer: table-driven runs, directed corner sequences and
// randomized runs against a timing/content model of the command replay.
module tb_spi_cfg_sequencer;

    localparam int DEPTH = 16;
    localparam int IDXW  = 4;
    localparam int SD    = 3;
    localparam int GAPC  = 5;

    logic        clk;
    logic        rst_in;
    logic        start_in;
    logic [4:0]  n_cmd_in;
    logic        tbl_we_in;
    logic [3:0]  tbl_idx_in;
    logic        tbl_tgt_in;
    logic [15:0] tbl_addr_in;
    logic [15:0] tbl_data_in;
`ifdef CFG_ABORT_EN
    logic        abort_in;
`endif
    logic        adc_cmd_trig_out;
    logic        dac_cmd_trig_out;
    logic [15:0] cmd_addr_out;
    logic [15:0] cmd_data_out;
    logic [3:0]  cmd_idx_out;
    logic        busy_out;
    logic        done_out;

    spi_cfg_sequencer #(
        .DEPTH       (DEPTH),
        .IDXW        (IDXW),
        .STARTUP_DLY (SD),
        .CMD_GAP     (GAPC)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .start_in         (start_in),
        .n_cmd_in         (n_cmd_in),
        .tbl_we_in        (tbl_we_in),
        .tbl_idx_in       (tbl_idx_in),
        .tbl_tgt_in       (tbl_tgt_in),
        .tbl_addr_in      (tbl_addr_in),
        .tbl_data_in      (tbl_data_in),
`ifdef CFG_ABORT_EN
        .abort_in         (abort_in),
`endif
        .adc_cmd_trig_out (adc_cmd_trig_out),
        .dac_cmd_trig_out (dac_cmd_trig_out),
        .cmd_addr_out     (cmd_addr_out),
        .cmd_data_out     (cmd_data_out),
        .cmd_idx_out      (cmd_idx_out),
        .busy_out         (busy_out),
        .done_out         (done_out)
    );

    typedef struct {
        int cyc;
        int tgt;
        int addr;
        int data;
        int idx;
    } trig_t;

    typedef struct {
        int n;
        int exp_trigs;
        int exp_done_off;
    } vec_t;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    busy_cnt = 0;
    trig_t trig_q[$];

    // Reference table contents as the host believes them to be
    int m_tgt  [DEPTH];
    int m_addr [DEPTH];
    int m_data [DEPTH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe triggers and busy cycles mid-cycle
    always @(negedge clk) begin
        trig_t r;
        if (adc_cmd_trig_out || dac_cmd_trig_out) begin
            r.cyc  = cyc;
            r.tgt  = (adc_cmd_trig_out && dac_cmd_trig_out) ? 2 : (dac_cmd_trig_out ? 1 : 0);
            r.addr = int'(cmd_addr_out);
            r.data = int'(cmd_data_out);
            r.idx  = int'(cmd_idx_out);
            trig_q.push_back(r);
        end
        if (busy_out) busy_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_entry(input int idx, input int tgt, input int addr, input int data);
        tbl_we_in   = 1'b1;
        tbl_idx_in  = 4'(idx);
        tbl_tgt_in  = 1'(tgt);
        tbl_addr_in = 16'(addr);
        tbl_data_in = 16'(data);
        tick();
        tbl_we_in   = 1'b0;
        m_tgt[idx]  = tgt;
        m_addr[idx] = addr;
        m_data[idx] = data;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_adc_trig"}, int'(adc_cmd_trig_out), 0);
        chk({tag, "_dac_trig"}, int'(dac_cmd_trig_out), 0);
        chk({tag, "_addr"},     int'(cmd_addr_out), 0);
        chk({tag, "_data"},     int'(cmd_data_out), 0);
        chk({tag, "_idx"},      int'(cmd_idx_out), 0);
        chk({tag, "_busy"},     int'(busy_out), 0);
        chk({tag, "_done"},     int'(done_out), 0);
    endtask

    // Start a run from IDLE and check it against the model.
    // noise: 0 quiet, 1 random start/write noise while busy, 2 directed start + entry-0 overwrite
    task automatic run_check(input int n, input int noise, input bit same_wr,
                             output int n_trig, output int done_off);
        int t, n_eff, exp_done, budget;
        n_eff = (n > DEPTH) ? DEPTH : n;
        trig_q.delete();
        busy_cnt = 0;
        t = cyc;
        n_cmd_in = 5'(n);
        start_in = 1'b1;
        if (same_wr) begin
            m_tgt[0]  = int'($urandom_range(0, 1));
            m_addr[0] = int'($urandom_range(0, 65535));
            m_data[0] = int'($urandom_range(0, 65535));
            tbl_we_in   = 1'b1;
            tbl_idx_in  = 4'd0;
            tbl_tgt_in  = 1'(m_tgt[0]);
            tbl_addr_in = 16'(m_addr[0]);
            tbl_data_in = 16'(m_data[0]);
        end
        tick();
        start_in  = 1'b0;
        tbl_we_in = 1'b0;
        n_cmd_in  = 5'($urandom_range(0, 31));
        chk("start_busy", int'(busy_out), 1);
        chk("start_done_clear", int'(done_out), 0);
        exp_done = (n_eff == 0) ? t + 2 : t + 1 + SD + n_eff * (GAPC + 1);
        budget = 0;
        while (!done_out && budget < 3000) begin
            if (noise == 1 && cyc < exp_done) begin
                start_in    = 1'($urandom_range(0, 1));
                n_cmd_in    = 5'($urandom_range(0, 31));
                tbl_we_in   = 1'($urandom_range(0, 1));
                tbl_idx_in  = 4'($urandom_range(0, 15));
                tbl_tgt_in  = 1'($urandom_range(0, 1));
                tbl_addr_in = 16'($urandom_range(0, 65535));
                tbl_data_in = 16'($urandom_range(0, 65535));
            end else if (noise == 2 && cyc == t + 5) begin
                start_in    = 1'b1;
                n_cmd_in    = 5'd1;
                tbl_we_in   = 1'b1;
                tbl_idx_in  = 4'd0;
                tbl_tgt_in  = 1'b1;
                tbl_addr_in = 16'hFFFF;
                tbl_data_in = 16'hFFFF;
            end
            tick();
            budget++;
            start_in  = 1'b0;
            tbl_we_in = 1'b0;
        end
        chk("done_cycle", cyc, exp_done);
        chk("busy_cycles", busy_cnt, exp_done - t - 1);
        chk("trig_count", trig_q.size(), n_eff);
        for (int k = 0; k < trig_q.size() && k < n_eff; k++) begin
            chk($sformatf("trig%0d_cyc", k),  trig_q[k].cyc,  t + 1 + SD + k * (GAPC + 1));
            chk($sformatf("trig%0d_tgt", k),  trig_q[k].tgt,  m_tgt[k]);
            chk($sformatf("trig%0d_addr", k), trig_q[k].addr, m_addr[k]);
            chk($sformatf("trig%0d_data", k), trig_q[k].data, m_data[k]);
            chk($sformatf("trig%0d_idx", k),  trig_q[k].idx,  k);
        end
        if (n_eff > 0) begin
            chk("hold_addr", int'(cmd_addr_out), m_addr[n_eff-1]);
            chk("hold_idx",  int'(cmd_idx_out),  n_eff - 1);
        end
        n_trig   = trig_q.size();
        done_off = cyc - t;
        tick();
        tick();
        chk("done_sticky", int'(done_out), 1);
    endtask

    vec_t vecs[6];

    initial begin
        int nt, doff, t, budget, cnt;

        vecs[0] = '{n: 3,  exp_trigs: 3,  exp_done_off: 22};
        vecs[1] = '{n: 0,  exp_trigs: 0,  exp_done_off: 2};
        vecs[2] = '{n: 1,  exp_trigs: 1,  exp_done_off: 10};
        vecs[3] = '{n: 21, exp_trigs: 16, exp_done_off: 100};
        vecs[4] = '{n: 16, exp_trigs: 16, exp_done_off: 100};
        vecs[5] = '{n: 2,  exp_trigs: 2,  exp_done_off: 16};

        rst_in = 1'b1;
        start_in = 1'b0;
        n_cmd_in = '0;
        tbl_we_in = 1'b0;
        tbl_idx_in = '0;
        tbl_tgt_in = 1'b0;
        tbl_addr_in = '0;
        tbl_data_in = '0;
`ifdef CFG_ABORT_EN
        abort_in = 1'b0;
`endif
        tick();
        tick();
        tick();
        rst_in = 1'b0;
        check_zero_outputs("reset");

        write_entry(0, 0, 16'h0001, 16'h0080);
        write_entry(1, 1, 16'h0002, 16'h0000);
        write_entry(2, 0, 16'h0003, 16'h0041);
        while (cyc < 10) tick();

        // Table of runs; entries 3.. are loaded before the runs that need them
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                for (int j = 3; j < DEPTH; j++) begin
                    write_entry(j, int'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                                int'($urandom_range(0, 65535)));
                end
            end
            run_check(vecs[i].n, 0, 1'b0, nt, doff);
            chk($sformatf("vec%0d_ntrig", i), nt, vecs[i].exp_trigs);
            chk($sformatf("vec%0d_done_off", i), doff, vecs[i].exp_done_off);
        end

        // Start and entry-0 overwrite while busy are ignored; a second run replays originals
        run_check(3, 2, 1'b0, nt, doff);
        run_check(3, 0, 1'b0, nt, doff);

        // Write and start in the same cycle: the run uses the new entry
        run_check(2, 0, 1'b1, nt, doff);

        // Reset in the gap after trigger 1
        trig_q.delete();
        n_cmd_in = 5'd3;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        budget = 0;
        while (trig_q.size() < 1 && budget < 200) begin
            tick();
            budget++;
        end
        chk("rst_seq_first_trig", trig_q.size(), 1);
        tick();
        tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check_zero_outputs("midrst");
        cnt = trig_q.size();
        repeat (40) tick();
        chk("midrst_no_more_trig", trig_q.size(), cnt);
        run_check(3, 0, 1'b0, nt, doff);

`ifdef CFG_ABORT_EN
        // Abort in the gap after trigger 1
        trig_q.delete();
        t = cyc;
        n_cmd_in = 5'd3;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        while (cyc < t + 1 + SD + 2) tick();
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        chk("abort_gap_done", int'(done_out), 1);
        chk("abort_gap_busy", int'(busy_out), 0);
        repeat (30) tick();
        chk("abort_gap_ntrig", trig_q.size(), 1);

        // Abort on the issue cycle of trigger 2
        trig_q.delete();
        t = cyc;
        n_cmd_in = 5'd3;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        while (cyc < t + 1 + SD + (GAPC + 1)) tick();
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        chk("abort_issue_done", int'(done_out), 1);
        repeat (30) tick();
        chk("abort_issue_ntrig", trig_q.size(), 2);
`endif

        // Randomized runs with random table updates and busy-time noise
        for (int r = 0; r < 6; r++) begin
            int nw;
            nw = int'($urandom_range(1, 4));
            for (int w = 0; w < nw; w++) begin
                write_entry(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                            int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
            end
            run_check(int'($urandom_range(0, DEPTH + 3)), 1, 1'($urandom_range(0, 1)), nt, doff);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
